// File: rtl/resp_window_checker.sv
// rtl/resp_window_checker.sv - multi-channel trigger/response window checker
// Each sampled trigger must see a response within [MIN_DLY, MAX_DLY] cycles.
module resp_window_checker #(
    parameter int NUM_CH  = 4,
    parameter int MIN_DLY = 2,
    parameter int MAX_DLY = 2,
    parameter int CNT_W   = 16,
    localparam int CH_W   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              en,
    input  logic              clr,
    input  logic [NUM_CH-1:0] trig,
    input  logic [NUM_CH-1:0] resp,
    output logic [NUM_CH-1:0] pass_pulse,
    output logic [NUM_CH-1:0] fail_pulse,
    output logic [NUM_CH-1:0] err_sticky,
    output logic [CH_W-1:0]   first_fail_ch,
    output logic              first_fail_vld,
    output logic [CNT_W-1:0]  pass_cnt,
    output logic [CNT_W-1:0]  fail_cnt
);
    localparam int NUM_W = $clog2(NUM_CH * MAX_DLY + 1);
    localparam int SUM_W = CNT_W + NUM_W;
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic [NUM_CH-1:0][MAX_DLY-1:0] pend_q, pend_d;
    logic [NUM_CH-1:0] res_pass_q, res_pass_d;
    logic [NUM_CH-1:0] res_fail_q, res_fail_d;
    logic [NUM_W-1:0]  pass_num_q, pass_num_d;
    logic [NUM_W-1:0]  fail_num_q, fail_num_d;
    logic [NUM_CH-1:0] pass_pulse_q, pass_pulse_d;
    logic [NUM_CH-1:0] fail_pulse_q, fail_pulse_d;
    logic [NUM_CH-1:0] err_sticky_q, err_sticky_d;
    logic [CH_W-1:0]   first_fail_ch_q, first_fail_ch_d;
    logic              first_fail_vld_q, first_fail_vld_d;
    logic [CNT_W-1:0]  pass_cnt_q, pass_cnt_d;
    logic [CNT_W-1:0]  fail_cnt_q, fail_cnt_d;

    function automatic logic [CNT_W-1:0] sat_add(input logic [CNT_W-1:0] a,
                                                 input logic [NUM_W-1:0] b);
        logic [SUM_W-1:0] s;
        s = SUM_W'(a) + SUM_W'(b);
        if (s > SUM_W'(CNT_MAX)) begin
            return CNT_MAX;
        end
        return s[CNT_W-1:0];
    endfunction

    // Stage 1: resolve attempts against resp and age the pending vectors.
    // pend_q[c][k] is an attempt that is age k+1 at the current edge.
    always_comb begin
        pend_d     = pend_q;
        res_pass_d = '0;
        res_fail_d = '0;
        pass_num_d = '0;
        fail_num_d = '0;
        for (int c = 0; c < NUM_CH; c++) begin
            for (int k = 0; k < MAX_DLY; k++) begin
                if (pend_q[c][k] && resp[c] && (k + 1 >= MIN_DLY)) begin
                    res_pass_d[c] = 1'b1;
                    pass_num_d    = pass_num_d + NUM_W'(1);
                end
            end
            if (pend_q[c][MAX_DLY-1] && !resp[c]) begin
                res_fail_d[c] = 1'b1;
                fail_num_d    = fail_num_d + NUM_W'(1);
            end
            // New attempts enter after resolution, so the birth-edge resp is never seen.
            pend_d[c][0] = en && trig[c];
            for (int k = 1; k < MAX_DLY; k++) begin
                pend_d[c][k] = pend_q[c][k-1] && !(resp[c] && (k >= MIN_DLY));
            end
        end
        if (clr) begin
            pend_d     = '0;
            res_pass_d = '0;
            res_fail_d = '0;
            pass_num_d = '0;
            fail_num_d = '0;
        end
    end

    // Stage 2: pulses, sticky state, first failure and saturating counters.
    always_comb begin
        pass_pulse_d     = res_pass_q;
        fail_pulse_d     = res_fail_q;
        err_sticky_d     = err_sticky_q | res_fail_q;
        first_fail_ch_d  = first_fail_ch_q;
        first_fail_vld_d = first_fail_vld_q;
        if (!first_fail_vld_q && (|res_fail_q)) begin
            first_fail_vld_d = 1'b1;
            for (int c = NUM_CH - 1; c >= 0; c--) begin
                if (res_fail_q[c]) begin
                    first_fail_ch_d = CH_W'(c);
                end
            end
        end
        pass_cnt_d = sat_add(pass_cnt_q, pass_num_q);
        fail_cnt_d = sat_add(fail_cnt_q, fail_num_q);
        if (clr) begin
            pass_pulse_d     = '0;
            fail_pulse_d     = '0;
            err_sticky_d     = '0;
            first_fail_ch_d  = '0;
            first_fail_vld_d = 1'b0;
            pass_cnt_d       = '0;
            fail_cnt_d       = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pend_q           <= '0;
            res_pass_q       <= '0;
            res_fail_q       <= '0;
            pass_num_q       <= '0;
            fail_num_q       <= '0;
            pass_pulse_q     <= '0;
            fail_pulse_q     <= '0;
            err_sticky_q     <= '0;
            first_fail_ch_q  <= '0;
            first_fail_vld_q <= 1'b0;
            pass_cnt_q       <= '0;
            fail_cnt_q       <= '0;
        end else begin
            pend_q           <= pend_d;
            res_pass_q       <= res_pass_d;
            res_fail_q       <= res_fail_d;
            pass_num_q       <= pass_num_d;
            fail_num_q       <= fail_num_d;
            pass_pulse_q     <= pass_pulse_d;
            fail_pulse_q     <= fail_pulse_d;
            err_sticky_q     <= err_sticky_d;
            first_fail_ch_q  <= first_fail_ch_d;
            first_fail_vld_q <= first_fail_vld_d;
            pass_cnt_q       <= pass_cnt_d;
            fail_cnt_q       <= fail_cnt_d;
        end
    end

    assign pass_pulse     = pass_pulse_q;
    assign fail_pulse     = fail_pulse_q;
    assign err_sticky     = err_sticky_q;
    assign first_fail_ch  = first_fail_ch_q;
    assign first_fail_vld = first_fail_vld_q;
    assign pass_cnt       = pass_cnt_q;
    assign fail_cnt       = fail_cnt_q;

endmodule

// File: tb/tb_resp_window_checker.sv
// tb/tb_resp_window_checker.sv - bench for resp_window_checker (two parameter sets)
module tb_resp_window_checker;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_n, en, clr;
    logic [3:0] trig, resp;
    logic [3:0] pp_a, fp_a, st_a, pp_b, fp_b, st_b;
    logic [1:0] ffc_a, ffc_b;
    logic       ffv_a, ffv_b;
    logic [15:0] pc_a, fc_a;
    logic [1:0]  pc_b, fc_b;

    resp_window_checker #(.NUM_CH(4), .MIN_DLY(2), .MAX_DLY(2), .CNT_W(16)) u_dut_a (
        .clk(clk), .rst_n(rst_n), .en(en), .clr(clr), .trig(trig), .resp(resp),
        .pass_pulse(pp_a), .fail_pulse(fp_a), .err_sticky(st_a),
        .first_fail_ch(ffc_a), .first_fail_vld(ffv_a), .pass_cnt(pc_a), .fail_cnt(fc_a));

    resp_window_checker #(.NUM_CH(4), .MIN_DLY(1), .MAX_DLY(3), .CNT_W(2)) u_dut_b (
        .clk(clk), .rst_n(rst_n), .en(en), .clr(clr), .trig(trig), .resp(resp),
        .pass_pulse(pp_b), .fail_pulse(fp_b), .err_sticky(st_b),
        .first_fail_ch(ffc_b), .first_fail_vld(ffv_b), .pass_cnt(pc_b), .fail_cnt(fc_b));

    typedef struct {
        logic r, e, c;
        logic [3:0] t, rs, pp, fp, st;
        logic fv;
        logic [1:0] fch;
        int pc, fc;
    } vec_t;
    typedef struct { logic [3:0] pp, fp; int np, nf; } res_t;
    typedef struct { logic [3:0] pp, fp, st; logic ffv; logic [1:0] ffc; int pc, fc; } exp_t;
    typedef struct { int inst; int ch; int born; } att_t;

    vec_t vecs[$];
    att_t att[$];
    res_t res_q0[$], res_q1[$];
    exp_t exp_m[2];
    int   ecnt, n_chk, n_pass;

    function automatic res_t zero_res();
        res_t z;
        z.pp = '0; z.fp = '0; z.np = 0; z.nf = 0;
        return z;
    endfunction

    function automatic exp_t zero_exp();
        exp_t z;
        z.pp = '0; z.fp = '0; z.st = '0; z.ffv = 1'b0; z.ffc = '0; z.pc = 0; z.fc = 0;
        return z;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        n_chk++;
        if (act === req) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, req);
    endtask

    // Reference: every attempt kept as (instance, channel, birth edge); results
    // of one edge are queued and show up on the outputs after the following edge.
    task automatic model_edge(input int i);
        int mn, mx, cmax, age;
        bit found;
        res_t prev, r;
        att_t keep[$];
        mn   = (i == 0) ? 2 : 1;
        mx   = (i == 0) ? 2 : 3;
        cmax = (i == 0) ? 65535 : 3;
        prev = zero_res();
        r    = zero_res();
        if (i == 0) begin
            if (res_q0.size() > 0) prev = res_q0.pop_front();
        end else begin
            if (res_q1.size() > 0) prev = res_q1.pop_front();
        end
        foreach (att[j]) if (att[j].inst != i) keep.push_back(att[j]);
        if (!rst_n || clr) begin
            exp_m[i] = zero_exp();
        end else begin
            exp_m[i].pp = prev.pp;
            exp_m[i].fp = prev.fp;
            exp_m[i].st = exp_m[i].st | prev.fp;
            if (!exp_m[i].ffv && prev.fp != 4'b0) begin
                exp_m[i].ffv = 1'b1;
                found = 1'b0;
                for (int c = 0; c < 4; c++) begin
                    if (prev.fp[c] && !found) begin
                        exp_m[i].ffc = 2'(c);
                        found = 1'b1;
                    end
                end
            end
            exp_m[i].pc = (exp_m[i].pc + prev.np > cmax) ? cmax : exp_m[i].pc + prev.np;
            exp_m[i].fc = (exp_m[i].fc + prev.nf > cmax) ? cmax : exp_m[i].fc + prev.nf;
            foreach (att[j]) begin
                if (att[j].inst == i) begin
                    age = ecnt - att[j].born;
                    if (age >= mn && resp[att[j].ch]) begin
                        r.pp[att[j].ch] = 1'b1;
                        r.np++;
                    end else if (age == mx) begin
                        r.fp[att[j].ch] = 1'b1;
                        r.nf++;
                    end else begin
                        keep.push_back(att[j]);
                    end
                end
            end
            for (int c = 0; c < 4; c++) begin
                if (en && trig[c]) keep.push_back('{i, c, ecnt});
            end
        end
        att = keep;
        if (i == 0) res_q0.push_back(r);
        else        res_q1.push_back(r);
    endtask

    task automatic cmp_model();
        chk("a.pass_pulse", 32'(pp_a), 32'(exp_m[0].pp));
        chk("a.fail_pulse", 32'(fp_a), 32'(exp_m[0].fp));
        chk("a.err_sticky", 32'(st_a), 32'(exp_m[0].st));
        chk("a.first_fail_vld", 32'(ffv_a), 32'(exp_m[0].ffv));
        chk("a.first_fail_ch", 32'(ffc_a), 32'(exp_m[0].ffc));
        chk("a.pass_cnt", 32'(pc_a), exp_m[0].pc);
        chk("a.fail_cnt", 32'(fc_a), exp_m[0].fc);
        chk("b.pass_pulse", 32'(pp_b), 32'(exp_m[1].pp));
        chk("b.fail_pulse", 32'(fp_b), 32'(exp_m[1].fp));
        chk("b.err_sticky", 32'(st_b), 32'(exp_m[1].st));
        chk("b.first_fail_vld", 32'(ffv_b), 32'(exp_m[1].ffv));
        chk("b.first_fail_ch", 32'(ffc_b), 32'(exp_m[1].ffc));
        chk("b.pass_cnt", 32'(pc_b), exp_m[1].pc);
        chk("b.fail_cnt", 32'(fc_b), exp_m[1].fc);
    endtask

    task automatic step(input logic r, input logic e, input logic c,
                        input logic [3:0] t, input logic [3:0] rs);
        rst_n = r; en = e; clr = c; trig = t; resp = rs;
        @(posedge clk);
        #1;
        model_edge(0);
        model_edge(1);
        ecnt++;
        cmp_model();
    endtask

    task automatic add(input logic r, input logic e, input logic c,
                       input logic [3:0] t, input logic [3:0] rs,
                       input logic [3:0] pp, input logic [3:0] fp, input logic [3:0] st,
                       input logic fv, input logic [1:0] fch, input int pc, input int fc);
        vec_t v;
        v.r = r; v.e = e; v.c = c; v.t = t; v.rs = rs;
        v.pp = pp; v.fp = fp; v.st = st; v.fv = fv; v.fch = fch; v.pc = pc; v.fc = fc;
        vecs.push_back(v);
    endtask

    initial begin
        rst_n = 1'b0; en = 1'b0; clr = 1'b0; trig = '0; resp = '0;
        ecnt = 0; n_chk = 0; n_pass = 0;
        exp_m[0] = zero_exp();
        exp_m[1] = zero_exp();

        // Expected values for instance a (MIN=MAX=2): r e c trig resp | pp fp st fv fch pc fc
        add(0,1,0,4'h0,4'h0, 4'h0,4'h0,4'h0,0,0,0,0);
        add(1,1,0,4'h0,4'h0, 4'h0,4'h0,4'h0,0,0,0,0);
        add(1,1,0,4'h1,4'h0, 4'h0,4'h0,4'h0,0,0,0,0);
        add(1,1,0,4'h0,4'h0, 4'h0,4'h0,4'h0,0,0,0,0);
        add(1,1,0,4'h0,4'h1, 4'h0,4'h0,4'h0,0,0,0,0);
        add(1,1,0,4'h0,4'h0, 4'h1,4'h0,4'h0,0,0,1,0);
        add(1,1,0,4'h0,4'h0, 4'h0,4'h0,4'h0,0,0,1,0);
        add(1,1,0,4'h1,4'h0, 4'h0,4'h0,4'h0,0,0,1,0);
        add(1,1,0,4'h0,4'h1, 4'h0,4'h0,4'h0,0,0,1,0);
        add(1,1,0,4'h0,4'h0, 4'h0,4'h0,4'h0,0,0,1,0);
        add(1,1,0,4'h0,4'h0, 4'h0,4'h1,4'h1,1,0,1,1);
        add(1,1,0,4'h0,4'h0, 4'h0,4'h0,4'h1,1,0,1,1);
        add(1,1,1,4'h0,4'h0, 4'h0,4'h0,4'h0,0,0,0,0);
        add(1,1,0,4'h6,4'h0, 4'h0,4'h0,4'h0,0,0,0,0);
        add(1,1,0,4'h0,4'h0, 4'h0,4'h0,4'h0,0,0,0,0);
        add(1,1,0,4'h1,4'h0, 4'h0,4'h0,4'h0,0,0,0,0);
        add(1,1,0,4'h0,4'h0, 4'h0,4'h6,4'h6,1,1,0,2);
        add(1,1,0,4'h0,4'h0, 4'h0,4'h0,4'h6,1,1,0,2);
        add(1,1,0,4'h0,4'h0, 4'h0,4'h1,4'h7,1,1,0,3);
        add(1,1,0,4'h0,4'h0, 4'h0,4'h0,4'h7,1,1,0,3);
        add(1,1,0,4'h8,4'h8, 4'h0,4'h0,4'h7,1,1,0,3);
        add(1,1,0,4'h8,4'h8, 4'h0,4'h0,4'h7,1,1,0,3);
        add(1,1,0,4'h8,4'h8, 4'h0,4'h0,4'h7,1,1,0,3);
        add(1,1,0,4'h8,4'h8, 4'h8,4'h0,4'h7,1,1,1,3);
        add(1,1,0,4'h0,4'h8, 4'h8,4'h0,4'h7,1,1,2,3);
        add(1,1,0,4'h0,4'h8, 4'h8,4'h0,4'h7,1,1,3,3);
        add(1,1,0,4'h0,4'h0, 4'h8,4'h0,4'h7,1,1,4,3);
        add(1,1,0,4'h0,4'h0, 4'h0,4'h0,4'h7,1,1,4,3);
        for (int k = 0; k < 4; k++) add(1,0,0,4'hF,4'h0, 4'h0,4'h0,4'h7,1,1,4,3);
        add(1,1,0,4'h0,4'h0, 4'h0,4'h0,4'h7,1,1,4,3);
        add(1,1,0,4'h0,4'h0, 4'h0,4'h0,4'h7,1,1,4,3);
        add(1,1,0,4'h1,4'h0, 4'h0,4'h0,4'h7,1,1,4,3);
        add(1,0,0,4'h0,4'h0, 4'h0,4'h0,4'h7,1,1,4,3);
        add(1,0,0,4'h0,4'h0, 4'h0,4'h0,4'h7,1,1,4,3);
        add(1,1,0,4'h0,4'h0, 4'h0,4'h1,4'h7,1,1,4,4);
        add(1,1,0,4'h0,4'h0, 4'h0,4'h0,4'h7,1,1,4,4);
        add(1,1,0,4'h1,4'h0, 4'h0,4'h0,4'h7,1,1,4,4);
        add(0,1,0,4'h0,4'h0, 4'h0,4'h0,4'h0,0,0,0,0);
        add(0,1,0,4'h0,4'h0, 4'h0,4'h0,4'h0,0,0,0,0);
        for (int k = 0; k < 4; k++) add(1,1,0,4'h0,4'h0, 4'h0,4'h0,4'h0,0,0,0,0);

        foreach (vecs[n]) begin
            step(vecs[n].r, vecs[n].e, vecs[n].c, vecs[n].t, vecs[n].rs);
            chk($sformatf("tbl%0d.pass_pulse", n), 32'(pp_a), 32'(vecs[n].pp));
            chk($sformatf("tbl%0d.fail_pulse", n), 32'(fp_a), 32'(vecs[n].fp));
            chk($sformatf("tbl%0d.err_sticky", n), 32'(st_a), 32'(vecs[n].st));
            chk($sformatf("tbl%0d.first_fail_vld", n), 32'(ffv_a), 32'(vecs[n].fv));
            chk($sformatf("tbl%0d.first_fail_ch", n), 32'(ffc_a), 32'(vecs[n].fch));
            chk($sformatf("tbl%0d.pass_cnt", n), 32'(pc_a), vecs[n].pc);
            chk($sformatf("tbl%0d.fail_cnt", n), 32'(fc_a), vecs[n].fc);
        end

        // Instance b (MIN=1, MAX=3): two overlapping attempts passed by one resp.
        step(1,1,1,4'h0,4'h0);
        repeat (4) step(1,1,0,4'h0,4'h0);
        step(1,1,0,4'h1,4'h0);
        step(1,1,0,4'h1,4'h0);
        step(1,1,0,4'h0,4'h1);
        step(1,1,0,4'h0,4'h0);
        chk("b.overlap_pass_pulse", 32'(pp_b), 32'h1);
        chk("b.overlap_pass_cnt", 32'(pc_b), 32'd2);
        step(1,1,0,4'h0,4'h0);
        step(1,1,0,4'h1,4'h0);
        repeat (3) step(1,1,0,4'h0,4'h0);
        chk("b.deadline_early_fail_pulse", 32'(fp_b), 32'h0);
        step(1,1,0,4'h0,4'h0);
        chk("b.deadline_fail_pulse", 32'(fp_b), 32'h1);
        chk("b.deadline_fail_cnt", 32'(fc_b), 32'd1);

        // Counter saturation at CNT_W=2, then clr on a resolving edge.
        for (int k = 0; k < 5; k++) begin
            step(1,1,0,4'h1,4'h0);
            step(1,1,0,4'h0,4'h1);
        end
        step(1,1,0,4'h0,4'h0);
        step(1,1,0,4'h0,4'h0);
        chk("b.sat_pass_cnt", 32'(pc_b), 32'd3);
        step(1,1,0,4'h1,4'h0);
        step(1,1,1,4'h0,4'h1);
        chk("b.clr_pass_cnt", 32'(pc_b), 32'd0);
        chk("b.clr_fail_cnt", 32'(fc_b), 32'd0);
        chk("b.clr_err_sticky", 32'(st_b), 32'd0);
        chk("b.clr_first_fail_vld", 32'(ffv_b), 32'd0);
        step(1,1,0,4'h0,4'h0);
        chk("b.post_clr_pass_pulse", 32'(pp_b), 32'd0);
        chk("b.post_clr_pass_cnt", 32'(pc_b), 32'd0);
        repeat (3) step(1,1,0,4'h0,4'h0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
